// File: rtl/model_share_arbiter.sv
// Round-robin front end sharing one two-bus compute unit between two requesters.
// Optional WAIT timeout abort: define MODEL_SHARE_ARBITER_TIMEOUT_EN.
module model_share_arbiter #(
  parameter int MSB     = 2,
  parameter int LSB     = -2,
  parameter int TIMEOUT = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [MSB:LSB] req0_i0,
  input  logic [LSB:MSB] req0_i1,
  input  logic [MSB:LSB] req1_i0,
  input  logic [LSB:MSB] req1_i1,
  output logic           unit_start,
  output logic [MSB:LSB] unit_i0,
  output logic [LSB:MSB] unit_i1,
  input  logic           unit_done,
  input  logic [MSB:LSB] unit_o0,
  input  logic [LSB:MSB] unit_o1,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [MSB:LSB] rsp_o0,
  output logic [LSB:MSB] rsp_o1,
  output logic           rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nx;
  logic   last;
  logic   gid;
  logic   tmo;

  // The requester after the last grant wins; fall back to the other one.
  always_comb begin
    gid = last;
    if (req_valid[!last]) gid = !last;
  end

  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && !rst && req_valid[gid])
      req_ready[gid] = 1'b1;
  end

  assign unit_start = (state == START);
  assign rsp_valid  = (state == RESP);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (|req_valid) state_nx = START;
      START: state_nx = WAIT;
      WAIT:  if (unit_done || tmo) state_nx = RESP;
      RESP:  if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last    <= 1'b1;
      rsp_id  <= 1'b0;
      unit_i0 <= '0;
      unit_i1 <= '0;
      rsp_o0  <= '0;
      rsp_o1  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            rsp_id  <= gid;
            unit_i0 <= gid ? req1_i0 : req0_i0;
            unit_i1 <= gid ? req1_i1 : req0_i1;
          end
        end
        WAIT: begin
          if (unit_done) begin
            rsp_o0 <= unit_o0;
            rsp_o1 <= unit_o1;
          end else if (tmo) begin
            rsp_o0 <= '0;
            rsp_o1 <= '0;
          end
        end
        RESP: if (rsp_ready) last <= rsp_id;
        default: ;
      endcase
    end
  end

`ifdef MODEL_SHARE_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          err_q;

  // cnt holds the number of WAIT cycles already spent without a done.
  assign tmo     = (state == WAIT) && (cnt == CW'(TIMEOUT - 1));
  assign rsp_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == START) cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CW'(1);
      if (state == WAIT) begin
        if (unit_done) err_q <= 1'b0;
        else if (tmo)  err_q <= 1'b1;
      end
    end
  end
`else
  assign tmo     = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/model_share_arbiter.md
Name: model_share_arbiter

Overview:
- Shares one instance of the two-bus compute unit (inputs i0[2:-2] and i1[-2:2]; outputs o0[2:-2] and o1[-2:2]) between two requesters.
- Round-robin arbitration; one transaction in flight at a time.
- Sequences each transaction as issue, wait for the unit's done, then return the response to the owning requester.
- Sits between the requester instances and the shared unit inside the top level.

Parameters:
- MSB, 2, upper index of both buses; i0/o0 ranges are [MSB:LSB], i1/o1 ranges are [LSB:MSB].
- LSB, -2, lower index of both buses (5 bits wide at defaults).
- TIMEOUT, 10, maximum WAIT cycles before the transaction is aborted (used only with the optional feature).

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  2  per-requester request; bit 0 is requester 0.
- req_ready  out  2  per-requester accept; at most one bit high per cycle.
- req0_i0 in [MSB:LSB]; req0_i1 in [LSB:MSB]; req1_i0 in [MSB:LSB]; req1_i1 in [LSB:MSB]  request operands.
- unit_start  out  1  one-cycle pulse launching the shared unit.
- unit_i0 out [MSB:LSB]; unit_i1 out [LSB:MSB]  operands held stable from START until done.
- unit_done  in  1  unit result valid, sampled in WAIT.
- unit_o0 in [MSB:LSB]; unit_o1 in [LSB:MSB]  unit results.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer accept.
- rsp_id  out  1  owner of the response.
- rsp_o0 out [MSB:LSB]; rsp_o1 out [LSB:MSB]  captured results.
- rsp_err  out  1  response is a timeout abort.

Behaviour:
- Reset values (asynchronous on rst=1): state IDLE, all outputs 0, last-grant pointer = 1 (requester 0 has priority first).
- Bit mapping: index k of any bus maps directly to index k of the connected bus; no reversal between the [MSB:LSB] and [LSB:MSB] buses.
- States: IDLE, START, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant the requester after last-grant in round-robin order.
  - Assert req_ready for the granted requester combinationally in this same cycle.
  - Capture its operands into unit_i0/unit_i1 and the owner id; go to START.
- START: unit_start=1 for exactly one cycle; go to WAIT.
- WAIT:
  - On unit_done=1, capture unit_o0/unit_o1 into rsp_o0/rsp_o1, set rsp_err=0, go to RESP.
  - unit_done outside WAIT is ignored.
- RESP:
  - rsp_valid=1; rsp_id, rsp_o0, rsp_o1 and rsp_err are held stable until rsp_ready=1.
  - On the cycle rsp_ready=1: update last-grant to rsp_id, clear rsp_valid, go to IDLE.
- Latency: request accept to unit_start is 1 cycle; unit_done to rsp_valid is 1 cycle; a new grant is possible the cycle after the response handshake.
- Both requesters valid in IDLE: the non-last-granted requester wins; the loser keeps req_valid asserted and is granted next.
- A requester dropping req_valid before its grant is legal; no state is kept for it.
- rsp_ready while rsp_valid=0 is ignored.
- unit_i0/unit_i1 keep their last values in IDLE; they are not cleared.
- rst asserted mid-transaction returns the block to the reset state immediately; no response is produced for the aborted transaction.

Optional Feature:
- Macro: MODEL_SHARE_ARBITER_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter clears on entry to WAIT.
  - If the count reaches TIMEOUT with no unit_done, go to RESP with rsp_err=1 and rsp_o0/rsp_o1 = 0.
  - unit_done arriving on the timeout cycle itself wins: normal response, rsp_err=0.
- Undefined: no counter; WAIT waits indefinitely; rsp_err is tied to 0.

Test Plan:
- Reset, then req_valid=01, req0_i0=5'b10110, req0_i1=5'b01101, unit returns o0=5'b11111, o1=5'b00001 three cycles after start:
  - Expect req_ready=01, then unit_start pulse, then unit_i0=10110 and unit_i1=01101.
  - Expect rsp_valid one cycle after unit_done with rsp_id=0, rsp_o0=11111, rsp_o1=00001, rsp_err=0.
- req_valid=11 held continuously for four transactions: grants alternate 0,1,0,1; exactly one unit_start per transaction.
- rsp_ready held 0 for 5 cycles in RESP: rsp_valid and all response fields stay stable; no new grant while req_valid=10; grant to requester 1 the cycle after rsp_ready=1.
- rst pulsed during WAIT, then unit_done: all outputs 0, unit_done ignored, next grant goes to requester 0.
- TIMEOUT_EN defined, TIMEOUT=10, unit_done never asserted: rsp_valid with rsp_err=1 and rsp_o0=rsp_o1=0 after 10 WAIT cycles. Repeat with unit_done on cycle 10: rsp_err=0.
- Bus-order check: drive req1_i1 with only index -2 set: only unit_i1 index -2 is set, confirming the [LSB:MSB] mapping is not reversed.
